// File: rtl/thread_sched_pkg.sv
// Shared definitions for the thread scheduler.
//   NUM_THREADS / THREAD_ID_WIDTH : default thread count and thread-id width
//   CNT_WIDTH                      : width of the per-thread penalty counter
//   DEFAULT_MISPREDICT_PENALTY     : default ineligible cycles after a mispredict
//   thread_state_e                 : per-thread scheduling state
package thread_sched_pkg;

  localparam int unsigned NUM_THREADS                = 4;
  localparam int unsigned THREAD_ID_WIDTH            = 2;
  localparam int unsigned CNT_WIDTH                  = 4;
  localparam int unsigned DEFAULT_MISPREDICT_PENALTY = 2;

  typedef enum logic [1:0] {
    StReady    = 2'd0,
    StMissWait = 2'd1,
    StPenalty  = 2'd2
  } thread_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
//   i_req_mask : one request bit per thread
//   i_ptr      : last granted index; the search starts strictly after it
//   o_grant    : index of the first requester above i_ptr, wrapping to 0
//   o_any      : at least one request bit is set (o_grant is 0 otherwise)
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req_mask,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [ID_W-1:0]    o_grant,
  output logic               o_any
);

  int unsigned scan_idx;

  always_comb begin
    o_grant  = '0;
    o_any    = 1'b0;
    scan_idx = 0;
    // k runs to NUM_REQ so the pointer itself is checked last: a lone
    // requester wins every cycle.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      scan_idx = (32'(i_ptr) + k) % NUM_REQ;
      if (!o_any && i_req_mask[scan_idx]) begin
        o_grant = ID_W'(scan_idx);
        o_any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/thread_scheduler.sv
// Fine-grained multithreading fetch scheduler.
// Tracks a READY / MISS_WAIT / PENALTY state per hardware thread and picks,
// every unstalled cycle, the next eligible thread in round-robin order.
//   i_Clk, i_Reset       : clock, synchronous active-high reset
//   i_Stall              : freezes grant outputs and pointer (thread FSMs still run)
//   i_thread_enable      : per-thread software enable (arbitration only)
//   i_miss_valid/_thread : I-cache miss event
//   i_miss_done          : per-thread refill complete pulse
//   i_mispredict_valid/_thread : branch mispredict event
//   o_thread_choice/_valid     : registered grant
//   o_thread_ready       : per-thread "state is READY"
module thread_scheduler #(
  parameter int unsigned NUM_THREADS        = thread_sched_pkg::NUM_THREADS,
  parameter int unsigned THREAD_ID_WIDTH    = thread_sched_pkg::THREAD_ID_WIDTH,
  // Legal range 1..15 (must fit the penalty counter and be non-zero).
  parameter int unsigned MISPREDICT_PENALTY = thread_sched_pkg::DEFAULT_MISPREDICT_PENALTY
) (
  input  logic                       i_Clk,
  input  logic                       i_Reset,
  input  logic                       i_Stall,
  input  logic [NUM_THREADS-1:0]     i_thread_enable,
  input  logic                       i_miss_valid,
  input  logic [THREAD_ID_WIDTH-1:0] i_miss_thread,
  input  logic [NUM_THREADS-1:0]     i_miss_done,
  input  logic                       i_mispredict_valid,
  input  logic [THREAD_ID_WIDTH-1:0] i_mispredict_thread,
  output logic [THREAD_ID_WIDTH-1:0] o_thread_choice,
  output logic                       o_thread_valid,
  output logic [NUM_THREADS-1:0]     o_thread_ready
);

  import thread_sched_pkg::*;

  localparam logic [CNT_WIDTH-1:0] PenaltyLoad = CNT_WIDTH'(MISPREDICT_PENALTY);
  localparam logic [CNT_WIDTH-1:0] CntOne      = CNT_WIDTH'(1);

  logic [NUM_THREADS-1:0] miss_hit;
  logic [NUM_THREADS-1:0] mp_hit;
  logic [NUM_THREADS-1:0] thread_ready;
  logic [NUM_THREADS-1:0] eligible;

  logic [THREAD_ID_WIDTH-1:0] choice_q;
  logic                       valid_q;
  logic [THREAD_ID_WIDTH-1:0] ptr_q;
  logic [THREAD_ID_WIDTH-1:0] winner;
  logic                       any_eligible;

  // ---------------------------------------------------------------------------
  // Per-thread state machines
  // ---------------------------------------------------------------------------
  for (genvar t = 0; t < NUM_THREADS; t++) begin : gen_thread
    thread_state_e        state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    assign miss_hit[t] = i_miss_valid && (i_miss_thread == THREAD_ID_WIDTH'(t));
    assign mp_hit[t]   = i_mispredict_valid && (i_mispredict_thread == THREAD_ID_WIDTH'(t));

    always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
        state_q <= StReady;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    // Mispredict beats everything; miss_done only matters in MISS_WAIT and a
    // miss only in READY, so their relative priority falls out of the state.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (mp_hit[t]) begin
        state_d = StPenalty;
        cnt_d   = PenaltyLoad;
      end else begin
        unique case (state_q)
          StReady: begin
            if (miss_hit[t]) state_d = StMissWait;
          end
          StMissWait: begin
            if (i_miss_done[t]) state_d = StReady;
          end
          StPenalty: begin
            // Counts through stalls; leaves on the cycle it reads 1.
            cnt_d = cnt_q - CntOne;
            if (cnt_q == CntOne) state_d = StReady;
          end
          default: begin
            state_d = StReady;
            cnt_d   = '0;
          end
        endcase
      end
    end

    always_comb begin
      thread_ready[t] = (state_q == StReady);
    end

    // Same-cycle events knock the thread out of this cycle's arbitration.
    assign eligible[t] = i_thread_enable[t] && thread_ready[t] && !miss_hit[t] && !mp_hit[t];
  end

  // ---------------------------------------------------------------------------
  // Round-robin grant
  // ---------------------------------------------------------------------------
  rr_arbiter #(
    .NUM_REQ (NUM_THREADS),
    .ID_W    (THREAD_ID_WIDTH)
  ) u_rr_arbiter (
    .i_req_mask (eligible),
    .i_ptr      (ptr_q),
    .o_grant    (winner),
    .o_any      (any_eligible)
  );

  // Pointer resets to the top index so the first grant after reset is thread 0.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      choice_q <= '0;
      valid_q  <= 1'b0;
      ptr_q    <= THREAD_ID_WIDTH'(NUM_THREADS - 1);
    end else if (!i_Stall) begin
      if (any_eligible) begin
        choice_q <= winner;
        valid_q  <= 1'b1;
        ptr_q    <= winner;
      end else begin
        valid_q  <= 1'b0;
      end
    end
  end

  assign o_thread_choice = choice_q;
  assign o_thread_valid  = valid_q;
  assign o_thread_ready  = thread_ready;

endmodule

// File: tb/tb_thread_scheduler.sv
module tb_thread_scheduler;

  localparam int NT  = 4;
  localparam int PEN = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic [3:0] en;
  logic       miss_v;
  logic [1:0] miss_t;
  logic [3:0] done;
  logic       mp_v;
  logic [1:0] mp_t;

  logic [1:0] o_thread_choice;
  logic       o_thread_valid;
  logic [3:0] o_thread_ready;
  logic [6:0] obs;

  int total = 0;
  int bad   = 0;

  // Reference model: 0 = READY, 1 = waiting on a miss, 2 = in penalty.
  int         m_st  [NT];
  int         m_cnt [NT];
  int         m_ptr;
  logic [1:0] m_choice;
  logic       m_valid;

  thread_scheduler #(
    .NUM_THREADS        (4),
    .THREAD_ID_WIDTH    (2),
    .MISPREDICT_PENALTY (PEN)
  ) dut (
    .i_Clk               (clk),
    .i_Reset             (rst),
    .i_Stall             (stall),
    .i_thread_enable     (en),
    .i_miss_valid        (miss_v),
    .i_miss_thread       (miss_t),
    .i_miss_done         (done),
    .i_mispredict_valid  (mp_v),
    .i_mispredict_thread (mp_t),
    .o_thread_choice     (o_thread_choice),
    .o_thread_valid      (o_thread_valid),
    .o_thread_ready      (o_thread_ready)
  );

  assign obs = {o_thread_choice, o_thread_valid, o_thread_ready};

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_outs();
    logic [3:0] r;
    for (int t = 0; t < NT; t++) r[t] = (m_st[t] == 0);
    return {m_choice, m_valid, r};
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  function automatic void model_step();
    bit elig [NT];
    int found;
    if (rst) begin
      for (int t = 0; t < NT; t++) begin
        m_st[t]  = 0;
        m_cnt[t] = 0;
      end
      m_ptr    = NT - 1;
      m_choice = 2'd0;
      m_valid  = 1'b0;
      return;
    end
    for (int t = 0; t < NT; t++)
      elig[t] = en[t] && (m_st[t] == 0) && !(miss_v && miss_t == t) && !(mp_v && mp_t == t);
    if (!stall) begin
      found = -1;
      for (int k = 1; k <= NT; k++)
        if (found < 0 && elig[(m_ptr + k) % NT]) found = (m_ptr + k) % NT;
      if (found >= 0) begin
        m_choice = found[1:0];
        m_valid  = 1'b1;
        m_ptr    = found;
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int t = 0; t < NT; t++) begin
      if (mp_v && mp_t == t) begin
        m_st[t]  = 2;
        m_cnt[t] = PEN;
      end else if (m_st[t] == 1) begin
        if (done[t]) m_st[t] = 0;
      end else if (m_st[t] == 0) begin
        if (miss_v && miss_t == t) m_st[t] = 1;
      end else begin
        if (m_cnt[t] == 1) m_st[t] = 0;
        m_cnt[t] = m_cnt[t] - 1;
      end
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    rst    = 1'b0;
    stall  = 1'b0;
    miss_v = 1'b0;
    miss_t = 2'd0;
    done   = 4'd0;
    mp_v   = 1'b0;
    mp_t   = 2'd0;
  endtask

  task automatic do_reset();
    clear_events();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    stall  = 1'($urandom);
    en     = 4'($urandom);
    miss_v = 1'b1;
    miss_t = 2'($urandom);
    done   = 4'($urandom);
    mp_v   = 1'b1;
    mp_t   = 2'($urandom);
    tick();
    total++;
    if (obs !== 7'b00_0_1111) begin
      bad++;
      $display("FAIL reset_values: got %b want %b", obs, 7'b00_0_1111);
    end
    total++;
    if (obs !== exp_outs()) begin
      bad++;
      $display("FAIL reset_model: got %b want %b", obs, exp_outs());
    end
    clear_events();
  endtask

  task automatic test_rotation();
    do_reset();
    en = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      tick();
      total++;
      if (o_thread_choice !== 2'(c % 4) || o_thread_valid !== 1'b1) begin
        bad++;
        $display("FAIL rotation c=%0d: got choice=%0d valid=%b want choice=%0d valid=1",
                 c, o_thread_choice, o_thread_valid, c % 4);
      end
    end
  endtask

  task automatic test_miss_rejoin();
    bit rejoined = 0;
    do_reset();
    en = 4'b1011;
    for (int c = 0; c < 14; c++) begin
      miss_v = (c == 3);
      miss_t = 2'd1;
      done   = (c == 8) ? 4'b0010 : 4'b0000;
      tick();
      total++;
      if (obs !== exp_outs()) begin
        bad++;
        $display("FAIL miss_model c=%0d: got %b want %b", c, obs, exp_outs());
      end
      if (o_thread_valid && o_thread_choice == 2'd2) begin
        bad++;
        $display("FAIL miss_disabled_grant c=%0d: got choice=2 want never 2", c);
      end
      if (c >= 3 && c <= 8 && o_thread_valid && o_thread_choice == 2'd1) begin
        bad++;
        $display("FAIL miss_outstanding_grant c=%0d: got choice=1 want not 1", c);
      end
      if (c > 8 && o_thread_valid && o_thread_choice == 2'd1) rejoined = 1;
    end
    clear_events();
    total++;
    if (!rejoined) begin
      bad++;
      $display("FAIL miss_rejoin: got no grant of thread 1 want a grant after refill");
    end
  endtask

  task automatic test_mispredict();
    bit regranted = 0;
    do_reset();
    en = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      mp_v = (c == 2);
      mp_t = 2'd2;
      tick();
      total++;
      if (o_thread_ready[2] !== !(c == 2 || c == 3)) begin
        bad++;
        $display("FAIL penalty_ready c=%0d: got %b want %b", c, o_thread_ready[2],
                 !(c == 2 || c == 3));
      end
      total++;
      if (obs !== exp_outs()) begin
        bad++;
        $display("FAIL penalty_model c=%0d: got %b want %b", c, obs, exp_outs());
      end
      if (c >= 2 && c <= 4 && o_thread_valid && o_thread_choice == 2'd2) begin
        bad++;
        $display("FAIL penalty_grant c=%0d: got choice=2 want not 2", c);
      end
      if (c > 4 && o_thread_valid && o_thread_choice == 2'd2) regranted = 1;
    end
    clear_events();
    total++;
    if (!regranted) begin
      bad++;
      $display("FAIL penalty_restore: got no grant of thread 2 want a grant after penalty");
    end
  endtask

  task automatic test_stall();
    do_reset();
    en = 4'b1111;
    tick();
    tick();
    for (int c = 0; c < 3; c++) begin
      stall = 1'b1;
      tick();
      total++;
      if (o_thread_choice !== 2'd1 || o_thread_valid !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold c=%0d: got choice=%0d valid=%b want choice=1 valid=1",
                 c, o_thread_choice, o_thread_valid);
      end
    end
    stall = 1'b0;
    tick();
    total++;
    if (o_thread_choice !== 2'd2 || o_thread_valid !== 1'b1) begin
      bad++;
      $display("FAIL stall_resume: got choice=%0d valid=%b want choice=2 valid=1",
               o_thread_choice, o_thread_valid);
    end
  endtask

  task automatic test_all_miss();
    do_reset();
    en = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      miss_v = (c < 4);
      miss_t = 2'(c);
      done   = (c == 7) ? 4'b1000 : 4'b0000;
      tick();
      if (c >= 3 && c <= 7) begin
        total++;
        if (o_thread_valid !== 1'b0 || o_thread_choice !== 2'd3) begin
          bad++;
          $display("FAIL all_miss_idle c=%0d: got choice=%0d valid=%b want choice=3 valid=0",
                   c, o_thread_choice, o_thread_valid);
        end
      end
      if (c == 8) begin
        total++;
        if (o_thread_valid !== 1'b1 || o_thread_choice !== 2'd3) begin
          bad++;
          $display("FAIL all_miss_wake: got choice=%0d valid=%b want choice=3 valid=1",
                   o_thread_choice, o_thread_valid);
        end
      end
      total++;
      if (obs !== exp_outs()) begin
        bad++;
        $display("FAIL all_miss_model c=%0d: got %b want %b", c, obs, exp_outs());
      end
    end
    clear_events();
  endtask

  task automatic test_priority_reset();
    do_reset();
    en     = 4'b1111;
    miss_v = 1'b1;
    miss_t = 2'd0;
    tick();
    clear_events();
    tick();
    // Mispredict and refill together: the mispredict must win.
    mp_v = 1'b1;
    mp_t = 2'd0;
    done = 4'b0001;
    tick();
    clear_events();
    total++;
    if (o_thread_ready[0] !== 1'b0) begin
      bad++;
      $display("FAIL prio_penalty: got ready0=%b want 0", o_thread_ready[0]);
    end
    // Reset in the middle of the penalty, with competing events.
    rst    = 1'b1;
    miss_v = 1'b1;
    miss_t = 2'd1;
    mp_v   = 1'b1;
    mp_t   = 2'd3;
    tick();
    clear_events();
    total++;
    if (obs !== 7'b00_0_1111) begin
      bad++;
      $display("FAIL prio_reset: got %b want %b", obs, 7'b00_0_1111);
    end
    tick();
    total++;
    if (obs !== 7'b00_1_1111) begin
      bad++;
      $display("FAIL prio_after_reset: got %b want %b", obs, 7'b00_1_1111);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (c % 16 == 0) en = 4'($urandom);
      rst    = ($urandom_range(63) == 0);
      stall  = ($urandom_range(3) == 0);
      miss_v = ($urandom_range(2) == 0);
      miss_t = 2'($urandom);
      done   = 4'($urandom & $urandom);
      mp_v   = ($urandom_range(7) == 0);
      mp_t   = 2'($urandom);
      tick();
      total++;
      if (obs !== exp_outs()) begin
        bad++;
        $display("FAIL random c=%0d: got %b want %b", c, obs, exp_outs());
      end
    end
    clear_events();
  endtask

  initial begin
    clear_events();
    en = 4'b1111;
    test_reset();
    test_rotation();
    test_miss_rejoin();
    test_mispredict();
    test_stall();
    test_all_miss();
    test_priority_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/thread_scheduler.md
THREAD_SCHEDULER -- requirements
Module: thread_scheduler

Interface
REQ-001 Parameter NUM_THREADS, 4, number of hardware threads sharing the fetch unit.
REQ-002 Parameter THREAD_ID_WIDTH, 2, width of thread identifiers; equals log2(NUM_THREADS).
REQ-003 Parameter MISPREDICT_PENALTY, 2, cycles a thread is ineligible after a mispredict; legal range 1..15.
REQ-004 i_Clk  in  1  sole clock; all state on rising edge.
REQ-005 i_Reset  in  1  synchronous, active-high reset.
REQ-006 i_Stall  in  1  pipeline stall; freezes grant outputs and the round-robin pointer.
REQ-007 i_thread_enable  in  NUM_THREADS  per-thread software enable.
REQ-008 i_miss_valid  in  1  I-cache miss reported this cycle.
REQ-009 i_miss_thread  in  THREAD_ID_WIDTH  thread owning the miss.
REQ-010 i_miss_done  in  NUM_THREADS  per-thread miss-refill complete pulse.
REQ-011 i_mispredict_valid  in  1  branch mispredict resolved this cycle.
REQ-012 i_mispredict_thread  in  THREAD_ID_WIDTH  thread owning the mispredict.
REQ-013 o_thread_choice  out  THREAD_ID_WIDTH  registered thread select; drives the fetch unit's thread-choice input.
REQ-014 o_thread_valid  out  1  registered; o_thread_choice names an eligible thread.
REQ-015 o_thread_ready  out  NUM_THREADS  registered; bit set when the thread is in READY.

Function
REQ-016 Each thread has a state: READY, MISS_WAIT or PENALTY, plus a 4-bit penalty counter.
REQ-017 READY -> MISS_WAIT on i_miss_valid for that thread; an i_miss_valid aimed at a thread not in READY is ignored.
REQ-018 MISS_WAIT -> READY on the thread's i_miss_done bit; i_miss_done in any other state is ignored.
REQ-019 On i_mispredict_valid the named thread enters PENALTY from any state and its counter loads MISPREDICT_PENALTY; an outstanding miss is abandoned.
REQ-020 Same-cycle priority for one thread: mispredict > miss_done > miss.
REQ-021 In PENALTY the counter decrements every cycle, including stalled cycles; on the cycle it reads 1 the thread returns to READY.
REQ-022 A thread is eligible when its enable bit is set, its state is READY, and it is not the target of a same-cycle miss or mispredict.
REQ-023 Grant rule: the first eligible thread strictly after the round-robin pointer, searching upward with wrap-around (NUM_THREADS-1 -> 0).
REQ-024 When !i_Stall and at least one thread is eligible: o_thread_choice <= the winner, o_thread_valid <= 1, and pointer <= the winner.
REQ-025 When !i_Stall and no thread is eligible: o_thread_valid <= 0; o_thread_choice and the pointer hold.
REQ-026 When i_Stall: o_thread_choice, o_thread_valid and the pointer hold; thread-state transitions still occur.
REQ-027 Latency: an event in cycle N affects eligibility in cycle N and appears on the outputs after edge N.
REQ-028 A single eligible thread is granted every cycle; there is no forced rotation.
REQ-029 Deasserting i_thread_enable removes the thread from arbitration only; its state machine keeps running.

Reset
REQ-030 When i_Reset is sampled high: all threads go to READY, counters clear to 0, pointer = NUM_THREADS-1, o_thread_choice = 0, o_thread_valid = 0, o_thread_ready = all ones.
REQ-031 Reset overrides all same-cycle events, including mid-miss and mid-penalty; pending events are discarded.

Structure
REQ-032 Package thread_sched_pkg holds the state enum (READY, MISS_WAIT, PENALTY), NUM_THREADS, THREAD_ID_WIDTH and the counter width.
REQ-033 Round-robin selection lives in a combinational sub-module rr_arbiter (inputs: request mask and pointer; outputs: grant index and any-grant).
REQ-034 The per-thread state machines are generated in a loop inside thread_scheduler.

Verification
REQ-035 All enabled, no events, no stall, after reset -> o_thread_choice sequence 0,1,2,3,0,... with o_thread_valid=1.
REQ-036 Enable=4'b1011, miss on thread 1 in cycle 3, i_miss_done[1] in cycle 8 -> thread 1 absent from grants between those cycles, rejoins afterwards, and thread 2 is never granted.
REQ-037 Mispredict on thread 2 with PENALTY=2 -> thread 2 not granted for 2 cycles, o_thread_ready[2] low for 2 cycles, then restored.
REQ-038 Stall held 3 cycles mid-rotation -> outputs frozen; rotation resumes with the next thread after the pre-stall grant.
REQ-039 All threads in MISS_WAIT -> o_thread_valid=0 and o_thread_choice held; first i_miss_done[3] -> next grant is 3.
REQ-040 Same-cycle mispredict and miss_done on thread 0, with reset asserted during a later PENALTY -> thread 0 enters PENALTY; reset returns all outputs to REQ-030 values.
